// File: rtl/kronos_mem_pkg.sv
// Shared types for the core-local SRAM front end: arbiter FSM states, grant ids and the
// byte-to-word address helper.
package kronos_mem_pkg;

  typedef enum logic {IDLE, RESP} arb_state_e;

  typedef enum logic {GNT_INSTR, GNT_DATA} grant_e;

  // SRAM is word addressed; the low two byte-address bits select lanes, which the mask covers.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection between the instruction and data ports, with the last-grant register
// that drives round-robin fairness.
module rr_arb2
  import kronos_mem_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic   clk,
  input  logic   rstz,
  input  logic   req_instr_i,
  input  logic   req_data_i,
  input  logic   issue_i,
  output grant_e grant_o
);

  grant_e last_q, last_d;

  always_comb begin
    grant_o = GNT_DATA;
    if (req_instr_i && req_data_i) begin
      if (FAIR) begin
        grant_o = (last_q == GNT_DATA) ? GNT_INSTR : GNT_DATA;
      end else begin
        grant_o = GNT_DATA;
      end
    end else if (req_instr_i) begin
      grant_o = GNT_INSTR;
    end
    last_d = issue_i ? grant_o : last_q;
  end

  // Reset to DATA so the first contention after reset goes to the fetch port.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      last_q <= GNT_DATA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wb_spsram_arbiter.sv
// Two-master (fetch + data) front end for the 32b single-port core-local SRAM: issue in IDLE,
// single-cycle ack in RESP, so every access completes one cycle after it is issued.
module wb_spsram_arbiter
  import kronos_mem_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask
);

  arb_state_e state_q, state_d;
  grant_e     grant_q, grant_d;
  grant_e     arb_grant;
  logic       issue;

  rr_arb2 #(
    .FAIR(FAIR)
  ) u_arb (
    .clk        (clk),
    .rstz       (rstz),
    .req_instr_i(instr_req),
    .req_data_i (data_req),
    .issue_i    (issue),
    .grant_o    (arb_grant)
  );

  // The SRAM holds its read data while disabled, so both read buses can pass it straight through.
  assign instr_data   = mem_rdata;
  assign data_rd_data = mem_rdata;
  assign mem_wdata    = data_wr_data;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    issue       = 1'b0;
    instr_ack   = 1'b0;
    data_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_mask = 4'b0000;
    mem_addr    = word_addr((arb_grant == GNT_INSTR) ? instr_addr : data_addr);

    case (state_q)
      IDLE: begin
        if (instr_req || data_req) begin
          issue   = rstz;
          mem_en  = rstz;
          grant_d = arb_grant;
          state_d = RESP;
          if (arb_grant == GNT_DATA) begin
            mem_wr_en   = data_wr_en & rstz;
            mem_wr_mask = data_mask;
          end
        end
      end
      // No issue here: the acked master still holds req during this cycle.
      RESP: begin
        instr_ack = rstz && (grant_q == GNT_INSTR);
        data_ack  = rstz && (grant_q == GNT_DATA);
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstz) begin
      state_q <= IDLE;
      grant_q <= GNT_DATA;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_spsram_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter, each on its own 256-word SRAM, checked every
// cycle against a transaction-level model plus directed hand-computed expectations.
module tb_wb_spsram_arbiter;

  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 0: FAIR=0, instance 1: FAIR=1
  logic [31:0] iaddr0, idata0, daddr0, dwd0, drd0, maddr0, mwd0, mrd0;
  logic [31:0] iaddr1, idata1, daddr1, dwd1, drd1, maddr1, mwd1, mrd1;
  logic [3:0]  dmask0, mmask0, dmask1, mmask1;
  logic        ireq0, iack0, dreq0, dwe0, dack0, men0, mwe0;
  logic        ireq1, iack1, dreq1, dwe1, dack1, men1, mwe1;

  logic [31:0] sram0 [256];
  logic [31:0] sram1 [256];

  // Transaction-level model state
  logic [31:0] ref_mem [2][256];
  int          m_ack   [2];
  bit          m_last  [2];
  logic [31:0] m_rd    [2];
  bit          m_rdv   [2];

  wb_spsram_arbiter #(.FAIR(1'b0)) dut0 (
    .clk(clk), .rstz(rstz),
    .instr_addr(iaddr0), .instr_req(ireq0), .instr_data(idata0), .instr_ack(iack0),
    .data_addr(daddr0), .data_wr_data(dwd0), .data_mask(dmask0), .data_wr_en(dwe0),
    .data_req(dreq0), .data_rd_data(drd0), .data_ack(dack0),
    .mem_addr(maddr0), .mem_wdata(mwd0), .mem_rdata(mrd0), .mem_en(men0),
    .mem_wr_en(mwe0), .mem_wr_mask(mmask0)
  );

  wb_spsram_arbiter #(.FAIR(1'b1)) dut1 (
    .clk(clk), .rstz(rstz),
    .instr_addr(iaddr1), .instr_req(ireq1), .instr_data(idata1), .instr_ack(iack1),
    .data_addr(daddr1), .data_wr_data(dwd1), .data_mask(dmask1), .data_wr_en(dwe1),
    .data_req(dreq1), .data_rd_data(drd1), .data_ack(dack1),
    .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrd1), .mem_en(men1),
    .mem_wr_en(mwe1), .mem_wr_mask(mmask1)
  );

  // Single-port SRAMs (DEPTH=256, word address wraps, rdata held while disabled)
  always @(posedge clk) begin
    if (men0) begin
      if (mwe0) begin
        for (int b = 0; b < 4; b++) if (mmask0[b]) sram0[maddr0[7:0]][8*b +: 8] <= mwd0[8*b +: 8];
      end else begin
        mrd0 <= sram0[maddr0[7:0]];
      end
    end
  end

  always @(posedge clk) begin
    if (men1) begin
      if (mwe1) begin
        for (int b = 0; b < 4; b++) if (mmask1[b]) sram1[maddr1[7:0]][8*b +: 8] <= mwd1[8*b +: 8];
      end else begin
        mrd1 <= sram1[maddr1[7:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // One cycle of the model: an access issues on any request when the previous cycle did not issue;
  // its ack follows one cycle later.
  task automatic cmp(input int k, input bit fair, input logic ireq, input logic dreq,
                     input logic dwe, input logic [31:0] iaddr, input logic [31:0] daddr,
                     input logic [31:0] dwd, input logic [3:0] dmask, input logic iack,
                     input logic dack, input logic en, input logic we, input logic [3:0] mask,
                     input logic [31:0] maddr, input logic [31:0] mwd, input logic [31:0] idata,
                     input logic [31:0] drd);
    bit          e_i, e_d, e_en, win_d;
    logic [31:0] a;
    logic [7:0]  idx;
    e_i  = rstz && (m_ack[k] == 1);
    e_d  = rstz && (m_ack[k] == 2);
    e_en = rstz && (m_ack[k] == 0) && (ireq || dreq);
    if (ireq && dreq) win_d = fair ? !m_last[k] : 1'b1;
    else              win_d = dreq;
    a   = win_d ? daddr : iaddr;
    idx = a[9:2];
    chk($sformatf("u%0d.instr_ack", k), 32'(iack), 32'(e_i));
    chk($sformatf("u%0d.data_ack", k), 32'(dack), 32'(e_d));
    chk($sformatf("u%0d.mem_en", k), 32'(en), 32'(e_en));
    if (e_i) chk($sformatf("u%0d.instr_data", k), idata, m_rd[k]);
    if (e_d && m_rdv[k]) chk($sformatf("u%0d.data_rd_data", k), drd, m_rd[k]);
    if (e_en) begin
      chk($sformatf("u%0d.mem_addr", k), maddr, {2'b00, a[31:2]});
      chk($sformatf("u%0d.mem_wr_en", k), 32'(we), 32'(win_d && dwe));
      chk($sformatf("u%0d.mem_wr_mask", k), 32'(mask), win_d ? 32'(dmask) : 32'd0);
      if (win_d && dwe) chk($sformatf("u%0d.mem_wdata", k), mwd, dwd);
    end
    if (!rstz) begin
      m_ack[k]  = 0;
      m_last[k] = 1'b1;
    end else if (e_en) begin
      m_ack[k]  = win_d ? 2 : 1;
      m_last[k] = win_d;
      if (win_d && dwe) begin
        for (int b = 0; b < 4; b++) if (dmask[b]) ref_mem[k][idx][8*b +: 8] = dwd[8*b +: 8];
        m_rdv[k] = 1'b0;
      end else begin
        m_rd[k]  = ref_mem[k][idx];
        m_rdv[k] = 1'b1;
      end
    end else begin
      m_ack[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    cmp(0, 1'b0, ireq0, dreq0, dwe0, iaddr0, daddr0, dwd0, dmask0, iack0, dack0, men0, mwe0,
        mmask0, maddr0, mwd0, idata0, drd0);
    cmp(1, 1'b1, ireq1, dreq1, dwe1, iaddr1, daddr1, dwd1, dmask1, iack1, dack1, men1, mwe1,
        mmask1, maddr1, mwd1, idata1, drd1);
  end

  // One access on the round-robin instance; lat is the ack cycle counted from issue (cycle 0).
  task automatic access1(input bit is_instr, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] m, output logic [31:0] rd,
                         output int lat);
    @(posedge clk); #1;
    if (is_instr) begin
      iaddr1 = addr; ireq1 = 1'b1;
    end else begin
      daddr1 = addr; dwd1 = wd; dmask1 = m; dwe1 = we; dreq1 = 1'b1;
    end
    lat = -1;
    rd  = 32'hx;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (is_instr ? iack1 : dack1) begin
        lat = c;
        rd  = is_instr ? idata1 : drd1;
        break;
      end
    end
    @(posedge clk); #1;
    ireq1 = 1'b0;
    dreq1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lat, n_i, n_d;
    logic [15:0] pat;

    for (int i = 0; i < 256; i++) begin
      sram0[i] = '0; sram1[i] = '0; ref_mem[0][i] = '0; ref_mem[1][i] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 0; m_last[k] = 1'b1; m_rd[k] = '0; m_rdv[k] = 1'b0;
    end
    mrd0 = '0; mrd1 = '0;
    iaddr0 = '0; daddr0 = '0; dwd0 = '0; dmask0 = '0; dwe0 = 1'b0; ireq0 = 1'b0; dreq0 = 1'b0;
    iaddr1 = '0; daddr1 = '0; dwd1 = '0; dmask1 = '0; dwe1 = 1'b0;
    ireq1  = 1'b1; dreq1 = 1'b1;
    rstz   = 1'b0;

    // Reset holds everything quiet even with both requests up
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.mem_en", 32'(men1), 32'd0);
    chk("reset.instr_ack", 32'(iack1), 32'd0);
    chk("reset.data_ack", 32'(dack1), 32'd0);
    @(posedge clk); #1;
    ireq1 = 1'b0; dreq1 = 1'b0; rstz = 1'b1;

    // Full write then fetch of the same word
    access1(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("wr_full.latency", lat, 1);
    access1(1'b1, 1'b0, 32'h10, '0, '0, rd, lat);
    chk("fetch.latency", lat, 1);
    chk("fetch.data", rd, 32'hDEADBEEF);

    // Lane-1 write, then a zero-mask write that must leave memory untouched
    access1(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, lat);
    access1(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, lat);
    chk("wr_nomask.latency", lat, 1);
    access1(1'b0, 1'b0, 32'h10, '0, '0, rd, lat);
    chk("rd_partial.data", rd, 32'hDEADAAEF);

    // Word 256 aliases word 0; fetch with a write pending on the idle data port
    access1(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, rd, lat);
    access1(1'b0, 1'b0, 32'h0, '0, '0, rd, lat);
    chk("alias.data_rd", rd, 32'hCAFEF00D);
    dwe1 = 1'b1; dmask1 = 4'hF; dwd1 = 32'h11111111;
    access1(1'b1, 1'b0, 32'h400, '0, '0, rd, lat);
    chk("alias.fetch", rd, 32'hCAFEF00D);
    dwe1 = 1'b0;

    // Reset asserted during the response cycle
    @(posedge clk); #1;
    daddr1 = 32'h10; dwe1 = 1'b0; dreq1 = 1'b1;
    @(negedge clk);
    chk("rst_resp.issue", 32'(men1), 32'd1);
    @(posedge clk); #1;
    rstz = 1'b0;
    @(negedge clk);
    chk("rst_resp.data_ack", 32'(dack1), 32'd0);
    chk("rst_resp.mem_en", 32'(men1), 32'd0);
    @(posedge clk); #1;
    rstz = 1'b1; dreq1 = 1'b0;
    @(negedge clk);
    chk("rst_resp.after", 32'(dack1), 32'd0);
    access1(1'b0, 1'b0, 32'h10, '0, '0, rd, lat);
    chk("rst_resp.recover_lat", lat, 1);
    chk("rst_resp.recover_data", rd, 32'hDEADAAEF);

    // Both requests up out of reset on the round-robin instance
    @(posedge clk); #1;
    rstz = 1'b0; iaddr1 = 32'h10; daddr1 = 32'h0; dwe1 = 1'b0; ireq1 = 1'b1; dreq1 = 1'b1;
    @(posedge clk); #1;
    rstz = 1'b1;
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pat = {pat[13:0], dack1, iack1};
    end
    chk("rr.ack_pattern", 32'(pat), 32'h1212);
    @(posedge clk); #1;
    ireq1 = 1'b0; dreq1 = 1'b0;

    // Fixed priority: data holds off fetch until it lets go
    @(posedge clk); #1;
    daddr0 = 32'h0; dwe0 = 1'b0; iaddr0 = 32'h4; dreq0 = 1'b1; ireq0 = 1'b1;
    n_i = 0; n_d = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_i += 32'(iack0);
      n_d += 32'(dack0);
    end
    chk("fp.instr_starved", n_i, 0);
    chk("fp.data_acks", n_d, 6);
    @(posedge clk); #1;
    dreq0 = 1'b0;
    lat = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (iack0) begin
        lat = c + 1;
        break;
      end
    end
    chk("fp.instr_wait", lat, 2);
    @(posedge clk); #1;
    ireq0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
